pc_fetch: RTL and testbench

Instruction-fetch front end of the five-stage MIPS pipeline. Owns the PC register and the next-PC selection, and drives the SRAM-like instruction-memory handshake. Consumes the ID-stage branch decision from the branch comparator together with jump/JR information and the exception redirect. Presents the fetched instruction, its PC and its delay-slot flag to the IF/ID register.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/pc_fetch_if.sv | 31 +++
 rtl/branch_target_calc.sv | 44 ++++
 rtl/pc_fetch.sv | 172 +++++++++++++++++
 tb/tb_pc_fetch.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch front end: FSM state
// encoding and the default reset PC.
// Revision: 1.0
// ---------------------------------------------------------------------------
package fetch_pkg;

  // S_REQ: request issued; S_WAIT: one request outstanding;
  // S_HOLD: instruction captured while IF is stalled
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

  // MIPS boot vector (kseg1 view of the boot ROM)
  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

endpackage
`default_nettype wire

// File: rtl/pc_fetch_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_fetch_if
// SRAM-like instruction-memory handshake: request/address out, separate
// address-accept and data-return strobes back.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface pc_fetch_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface
`default_nettype wire

// File: rtl/branch_target_calc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// branch_target_calc
// Combinational branch/jump target generation and next-PC priority mux.
// Revision: 1.0
// ---------------------------------------------------------------------------
module branch_target_calc (
  input  wire logic [31:0] pc_f,
  input  wire logic        branch_d,
  input  wire logic        jump_d,
  input  wire logic        jr_d,
  input  wire logic        branch_taken_d,
  input  wire logic [31:0] pc_plus4_d,
  input  wire logic [15:0] imm_d,
  input  wire logic [25:0] instr_index_d,
  input  wire logic [31:0] rs_d,
  output logic      [31:0] next_pc
);

  logic [31:0] branch_offset;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] seq_pc;

  // Sign-extended word offset; the add wraps modulo 2^32
  assign branch_offset = {{14{imm_d[15]}}, imm_d, 2'b00};
  assign branch_target = pc_plus4_d + branch_offset;
  assign jump_target   = {pc_plus4_d[31:28], instr_index_d, 2'b00};
  assign seq_pc        = pc_f + 32'd4;

  // Priority: J/JAL, then JR/JALR, then taken branch, else sequential
  always_comb begin
    next_pc = seq_pc;
    if (jump_d) begin
      next_pc = jump_target;
    end else if (jr_d) begin
      next_pc = rs_d;
    end else if (branch_d && branch_taken_d) begin
      next_pc = branch_target;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_fetch
// IF stage: PC register, next-PC selection and a single-outstanding
// instruction-memory request FSM with a hold buffer and stale-response
// discard after redirects.
// Revision: 1.0
// ---------------------------------------------------------------------------
module pc_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  wire logic        clk,
  input  wire logic        resetn,
  input  wire logic        stall_f,
  input  wire logic        flush_exc,
  input  wire logic [31:0] exc_pc,
  input  wire logic        branch_d,
  input  wire logic        jump_d,
  input  wire logic        jr_d,
  input  wire logic        branch_taken_d,
  input  wire logic [31:0] pc_plus4_d,
  input  wire logic [15:0] imm_d,
  input  wire logic [25:0] instr_index_d,
  input  wire logic [31:0] rs_d,
  pc_fetch_if.master       mem,
  output logic      [31:0] pc_f,
  output logic      [31:0] instr_f,
  output logic             instr_valid_f,
  output logic             fetch_stall,
  output logic             is_in_delayslot_f,
  output logic             adel_f
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc_nxt;
  logic [31:0]  buf_q, buf_nxt;
  logic         discard, discard_nxt;
  logic [31:0]  next_pc;
  logic         misaligned;
  logic         advance;

  branch_target_calc u_target (
    .pc_f           (pc_f),
    .branch_d       (branch_d),
    .jump_d         (jump_d),
    .jr_d           (jr_d),
    .branch_taken_d (branch_taken_d),
    .pc_plus4_d     (pc_plus4_d),
    .imm_d          (imm_d),
    .instr_index_d  (instr_index_d),
    .rs_d           (rs_d),
    .next_pc        (next_pc)
  );

  assign misaligned        = (pc_f[1:0] != 2'b00);
  assign advance           = instr_valid_f & ~stall_f & ~flush_exc;
  assign fetch_stall       = ~instr_valid_f;
  assign is_in_delayslot_f = branch_d | jump_d | jr_d;

  // Per-state outputs; a misaligned PC yields a faulting bubble without touching memory
  always_comb begin
    mem.inst_req  = 1'b0;
    mem.inst_addr = pc_f;
    instr_f       = 32'h0;
    instr_valid_f = 1'b0;
    adel_f        = 1'b0;
    unique case (state)
      S_REQ: begin
        if (misaligned) begin
          instr_valid_f = 1'b1;
          adel_f        = 1'b1;
        end else begin
          mem.inst_req = resetn;
        end
      end
      S_WAIT: begin
        if (mem.inst_data_ok && !discard) begin
          instr_valid_f = 1'b1;
          instr_f       = mem.inst_rdata;
        end
      end
      S_HOLD: begin
        instr_valid_f = 1'b1;
        instr_f       = buf_q;
      end
      default: ;
    endcase
    if (flush_exc) begin
      instr_valid_f = 1'b0;
    end
  end

  // Next-state logic: exception redirect overrides everything else
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc_f;
    buf_nxt     = buf_q;
    discard_nxt = discard;
    if (flush_exc) begin
      pc_nxt = exc_pc;
      unique case (state)
        S_REQ: begin
          // Accepted request would return data for the old PC
          if (mem.inst_req && mem.inst_addr_ok) begin
            state_nxt   = S_WAIT;
            discard_nxt = 1'b1;
          end
        end
        S_WAIT: begin
          if (mem.inst_data_ok) begin
            state_nxt   = S_REQ;
            discard_nxt = 1'b0;
          end else begin
            discard_nxt = 1'b1;
          end
        end
        S_HOLD:  state_nxt = S_REQ;
        default: state_nxt = S_REQ;
      endcase
    end else begin
      unique case (state)
        S_REQ: begin
          if (advance) begin
            pc_nxt = next_pc;
          end else if (mem.inst_req && mem.inst_addr_ok) begin
            state_nxt = S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem.inst_data_ok) begin
            if (discard) begin
              discard_nxt = 1'b0;
              state_nxt   = S_REQ;
            end else if (advance) begin
              pc_nxt    = next_pc;
              state_nxt = S_REQ;
            end else begin
              buf_nxt   = mem.inst_rdata;
              state_nxt = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (advance) begin
            pc_nxt    = next_pc;
            state_nxt = S_REQ;
          end
        end
        default: state_nxt = S_REQ;
      endcase
    end
  end

  // State, PC, hold buffer and discard flag registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= S_REQ;
      pc_f    <= RESET_PC;
      buf_q   <= 32'h0;
      discard <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc_f    <= pc_nxt;
      buf_q   <= buf_nxt;
      discard <= discard_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pc_fetch
// Directed bench for pc_fetch with expected fetch addresses and returned
// instructions queued as stimulus is driven.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_pc_fetch;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        stall_f;
  logic        flush_exc;
  logic [31:0] exc_pc;
  logic        branch_d, jump_d, jr_d, branch_taken_d;
  logic [31:0] pc_plus4_d;
  logic [15:0] imm_d;
  logic [25:0] instr_index_d;
  logic [31:0] rs_d;
  logic [31:0] pc_f, instr_f;
  logic        instr_valid_f, fetch_stall, is_in_delayslot_f, adel_f;

  pc_fetch_if mem ();

  pc_fetch #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .stall_f           (stall_f),
    .flush_exc         (flush_exc),
    .exc_pc            (exc_pc),
    .branch_d          (branch_d),
    .jump_d            (jump_d),
    .jr_d              (jr_d),
    .branch_taken_d    (branch_taken_d),
    .pc_plus4_d        (pc_plus4_d),
    .imm_d             (imm_d),
    .instr_index_d     (instr_index_d),
    .rs_d              (rs_d),
    .mem               (mem),
    .pc_f              (pc_f),
    .instr_f           (instr_f),
    .instr_valid_f     (instr_valid_f),
    .fetch_stall       (fetch_stall),
    .is_in_delayslot_f (is_in_delayslot_f),
    .adel_f            (adel_f)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] addr_q[$];
  logic [31:0] data_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    #1;
    while (mem.inst_req !== 1'b1 && n < 20) begin
      step();
      #1;
      n++;
    end
    check({tag, "_req"}, 32'(mem.inst_req), 32'd1);
  endtask

  // One aligned fetch: accept address, return data, optionally stall IF
  task automatic fetch(input string tag, input logic [31:0] data,
                       input int stall_cycles, input logic exp_ds);
    logic [31:0] a;
    logic [31:0] d;
    wait_req(tag);
    a = addr_q.pop_front();
    check({tag, "_addr"}, mem.inst_addr, a);
    check({tag, "_pc"}, pc_f, a);
    mem.inst_addr_ok = 1'b1;
    step();
    mem.inst_addr_ok = 1'b0;
    #1;
    check({tag, "_wait_req"}, 32'(mem.inst_req), 32'd0);
    check({tag, "_wait_stall"}, 32'(fetch_stall), 32'd1);
    mem.inst_data_ok = 1'b1;
    mem.inst_rdata   = data;
    data_q.push_back(data);
    stall_f = (stall_cycles > 0);
    #1;
    d = data_q.pop_front();
    check({tag, "_valid"}, 32'(instr_valid_f), 32'd1);
    check({tag, "_instr"}, instr_f, d);
    check({tag, "_ds"}, 32'(is_in_delayslot_f), 32'(exp_ds));
    step();
    mem.inst_data_ok = 1'b0;
    mem.inst_rdata   = 32'hA5A5_A5A5;
    if (stall_cycles > 0) begin
      for (int k = 1; k < stall_cycles; k++) begin
        #1;
        check({tag, "_hold_instr"}, instr_f, d);
        check({tag, "_hold_valid"}, 32'(instr_valid_f), 32'd1);
        check({tag, "_hold_req"}, 32'(mem.inst_req), 32'd0);
        step();
      end
      stall_f = 1'b0;
      #1;
      check({tag, "_release_req"}, 32'(mem.inst_req), 32'd0);
      check({tag, "_release_instr"}, instr_f, d);
      step();
    end
  endtask

  initial begin
    resetn = 1'b0; stall_f = 1'b0; flush_exc = 1'b0; exc_pc = 32'h0;
    branch_d = 1'b0; jump_d = 1'b0; jr_d = 1'b0; branch_taken_d = 1'b0;
    pc_plus4_d = 32'h0; imm_d = 16'h0; instr_index_d = 26'h0; rs_d = 32'h0;
    mem.inst_addr_ok = 1'b0; mem.inst_data_ok = 1'b0; mem.inst_rdata = 32'h0;

    // Reset held for two cycles
    step();
    step();
    check("rst_req", 32'(mem.inst_req), 32'd0);
    check("rst_pc", pc_f, 32'hBFC0_0000);
    check("rst_valid", 32'(instr_valid_f), 32'd0);
    check("rst_adel", 32'(adel_f), 32'd0);
    resetn = 1'b1;

    // Boot fetch, then sequential fetch
    addr_q.push_back(32'hBFC0_0000);
    fetch("boot", 32'h2408_0001, 0, 1'b0);
    #1;
    check("boot_once", 32'(instr_valid_f), 32'd0);
    addr_q.push_back(32'hBFC0_0004);
    fetch("seq4", 32'h0000_0000, 0, 1'b0);

    // Taken branch with delay slot at 0xBFC00008
    branch_d = 1'b1; branch_taken_d = 1'b1; pc_plus4_d = 32'hBFC0_0008; imm_d = 16'hFFFE;
    addr_q.push_back(32'hBFC0_0008);
    fetch("br_t", 32'h1111_0000, 0, 1'b1);
    branch_d = 1'b0; branch_taken_d = 1'b0;

    // Walk back to 0xBFC00008 and repeat with a not-taken branch
    addr_q.push_back(32'hBFC0_0000);
    fetch("walk0", 32'h1111_0001, 0, 1'b0);
    addr_q.push_back(32'hBFC0_0004);
    fetch("walk4", 32'h1111_0002, 0, 1'b0);
    branch_d = 1'b1; branch_taken_d = 1'b0;
    addr_q.push_back(32'hBFC0_0008);
    fetch("br_nt", 32'h1111_0003, 0, 1'b1);
    branch_d = 1'b0;

    // Jump
    jump_d = 1'b1; pc_plus4_d = 32'hBFC0_0010; instr_index_d = 26'h000_0100;
    addr_q.push_back(32'hBFC0_000C);
    fetch("jump", 32'h1111_0004, 0, 1'b1);
    jump_d = 1'b0;

    // Stall while data arrives: held in buffer for three stall cycles
    addr_q.push_back(32'hB000_0400);
    fetch("stall", 32'hDEAD_BEEF, 3, 1'b0);

    // Exception redirect while a request is outstanding
    addr_q.push_back(32'hB000_0404);
    wait_req("flush");
    check("flush_addr", mem.inst_addr, addr_q.pop_front());
    mem.inst_addr_ok = 1'b1;
    step();
    mem.inst_addr_ok = 1'b0;
    flush_exc = 1'b1;
    exc_pc = 32'hBFC0_0380;
    #1;
    check("flush_valid0", 32'(instr_valid_f), 32'd0);
    step();
    flush_exc = 1'b0;
    #1;
    check("flush_pc", pc_f, 32'hBFC0_0380);
    check("flush_wait_req", 32'(mem.inst_req), 32'd0);
    step();
    mem.inst_data_ok = 1'b1;
    mem.inst_rdata   = 32'h1234_5678;
    #1;
    check("flush_drop_valid", 32'(instr_valid_f), 32'd0);
    step();
    mem.inst_data_ok = 1'b0;

    // Redirected fetch holds a JR in ID targeting a misaligned address
    jr_d = 1'b1; rs_d = 32'h8000_0002;
    addr_q.push_back(32'hBFC0_0380);
    fetch("exc", 32'h2222_0000, 0, 1'b1);
    rs_d = 32'hBFC0_0000;
    #1;
    check("adel_pc", pc_f, 32'h8000_0002);
    check("adel_req", 32'(mem.inst_req), 32'd0);
    check("adel_flag", 32'(adel_f), 32'd1);
    check("adel_valid", 32'(instr_valid_f), 32'd1);
    check("adel_instr", instr_f, 32'h0);
    step();
    jr_d = 1'b0;

    // Recovery to an aligned target
    addr_q.push_back(32'hBFC0_0000);
    fetch("recover", 32'h3333_0000, 0, 1'b0);
    #1;
    check("recover_pc", pc_f, 32'hBFC0_0004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
